// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the fetch/data request logic, the arbiter and the single RAM port.
// The arbiter takes the slave view; whoever drives the requests and models the RAM takes the master view.
interface cache_mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory, with a sticky hung-transfer flag.
// Define ARB_RR_EN for round-robin arbitration; otherwise data always wins over instruction.
module cache_mem_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic               CLK,
    input  logic               nRST,
    cache_mem_arbiter_if.slave bus,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             d_req;
    logic             pick_d;

    assign d_req = bus.dREN | bus.dWEN;

`ifdef ARB_RR_EN
    // Remembers whether the last grant went to the data side; resets to "instruction".
    logic last_d_q, last_d_d;

    assign pick_d = d_req & (~bus.iREN | ~last_d_q);

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && state_d != IDLE) begin
            last_d_d = (state_d == DGRANT);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // A grant ends on completion or when the owner withdraws; IDLE always follows (bubble).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = DGRANT;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                if (!bus.iREN || bus.ram_ready) begin
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                if (!d_req || bus.ram_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held at zero outside grants, so every grant starts counting from zero; saturates at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!bus.ram_ready && cnt_q != CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(TIMEOUT)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        case (state_q)
            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~(bus.iREN & bus.ram_ready);
            end
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = ~(d_req & bus.ram_ready);
            end
            default: begin
            end
        endcase
    end

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
    assign err       = err_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations, then sticky random traffic,
// all cross-checked every cycle against an ownership/age model of the RAM port.
module tb_cache_mem_arbiter;
    localparam int TO = 8;
    localparam int OWN_NONE = 0;
    localparam int OWN_I = 1;
    localparam int OWN_D = 2;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST = 1'b1;
    logic err;

    cache_mem_arbiter_if bus_if ();

    cache_mem_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_if.slave),
        .err  (err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM port, how long it has waited, and the sticky error.
    int owner = OWN_NONE;
    int age = 0;
    bit m_err = 1'b0;
    bit last_was_d = 1'b0;
    bit d_wants, i_wants, still;

    always @(posedge CLK) begin
        if (!nRST) begin
            owner = OWN_NONE;
            age = 0;
            m_err = 1'b0;
            last_was_d = 1'b0;
        end else if (owner == OWN_NONE) begin
            d_wants = bus_if.dREN | bus_if.dWEN;
            i_wants = bus_if.iREN;
            if (d_wants && i_wants) owner = (RR && last_was_d) ? OWN_I : OWN_D;
            else if (d_wants) owner = OWN_D;
            else if (i_wants) owner = OWN_I;
            if (owner != OWN_NONE) begin
                age = 0;
                last_was_d = (owner == OWN_D);
            end
        end else begin
            still = (owner == OWN_I) ? bus_if.iREN : (bus_if.dREN | bus_if.dWEN);
            if (!bus_if.ram_ready) begin
                if (age < TO) age++;
                if (age >= TO) m_err = 1'b1;
            end
            if (!still || bus_if.ram_ready) owner = OWN_NONE;
        end
    end

    bit cmp_en = 1'b0;
    int e_own;
    logic e_ren, e_wen, e_iwait, e_dwait;
    logic [31:0] e_addr, e_store;

    always @(negedge CLK) begin
        if (cmp_en) begin
            e_own = nRST ? owner : OWN_NONE;
            e_ren = 1'b0;
            e_wen = 1'b0;
            e_addr = 32'h0;
            e_store = 32'h0;
            e_iwait = 1'b1;
            e_dwait = 1'b1;
            if (e_own == OWN_I) begin
                e_ren = bus_if.iREN;
                e_addr = bus_if.iaddr;
                e_iwait = !(bus_if.iREN && bus_if.ram_ready);
            end else if (e_own == OWN_D) begin
                e_wen = bus_if.dWEN;
                e_ren = bus_if.dREN && !bus_if.dWEN;
                e_addr = bus_if.daddr;
                e_store = bus_if.dstore;
                e_dwait = !((bus_if.dREN || bus_if.dWEN) && bus_if.ram_ready);
            end
            chk("cyc_ramREN", {31'b0, bus_if.ramREN}, {31'b0, e_ren});
            chk("cyc_ramWEN", {31'b0, bus_if.ramWEN}, {31'b0, e_wen});
            chk("cyc_ramaddr", bus_if.ramaddr, e_addr);
            if (e_own != OWN_I) chk("cyc_ramstore", bus_if.ramstore, e_store);
            chk("cyc_iwait", {31'b0, bus_if.iwait}, {31'b0, e_iwait});
            chk("cyc_dwait", {31'b0, bus_if.dwait}, {31'b0, e_dwait});
            chk("cyc_err", {31'b0, err}, {31'b0, nRST ? m_err : 1'b0});
            if (!e_iwait) chk("cyc_iload", bus_if.iload, bus_if.ramload);
            if (!e_dwait) chk("cyc_dload", bus_if.dload, bus_if.ramload);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.iREN = 1'b0;
        bus_if.dREN = 1'b0;
        bus_if.dWEN = 1'b0;
        bus_if.ram_ready = 1'b0;
    endtask

    logic [4:0] pat;

    initial begin
        #1;
        nRST = 1'b0;
        idle_inputs();
        bus_if.iaddr = 32'h0;
        bus_if.daddr = 32'h0;
        bus_if.dstore = 32'h0;
        bus_if.ramload = 32'h0;
        cmp_en = 1'b1;
        mid();
        chk("reset_iwait", {31'b0, bus_if.iwait}, 32'd1);
        chk("reset_err", {31'b0, err}, 32'd0);
        step();
        step();
        nRST = 1'b1;
        step();

        // Reset while a write is being granted
        bus_if.dWEN = 1'b1;
        bus_if.daddr = 32'h300;
        bus_if.dstore = 32'h1234_5678;
        step();
        mid();
        chk("t1_wen_granted", {31'b0, bus_if.ramWEN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("t1_wen_in_reset", {31'b0, bus_if.ramWEN}, 32'd0);
        chk("t1_dwait_in_reset", {31'b0, bus_if.dwait}, 32'd1);
        chk("t1_addr_in_reset", bus_if.ramaddr, 32'h0);
        chk("t1_err_in_reset", {31'b0, err}, 32'd0);
        step();
        nRST = 1'b1;
        idle_inputs();
        mid();
        chk("t1_idle_after", {31'b0, bus_if.ramWEN}, 32'd0);
        step();

        // Instruction-only read, RAM answers on the third grant cycle
        bus_if.iREN = 1'b1;
        bus_if.iaddr = 32'h40;
        step();
        mid();
        chk("t2_ramREN", {31'b0, bus_if.ramREN}, 32'd1);
        chk("t2_ramaddr", bus_if.ramaddr, 32'h40);
        chk("t2_iwait_c1", {31'b0, bus_if.iwait}, 32'd1);
        step();
        mid();
        chk("t2_iwait_c2", {31'b0, bus_if.iwait}, 32'd1);
        step();
        bus_if.ram_ready = 1'b1;
        bus_if.ramload = 32'h2001_0005;
        mid();
        chk("t2_iwait_done", {31'b0, bus_if.iwait}, 32'd0);
        chk("t2_iload", bus_if.iload, 32'h2001_0005);
        step();
        bus_if.ram_ready = 1'b0;
        mid();
        chk("t2_bubble_ramREN", {31'b0, bus_if.ramREN}, 32'd0);
        chk("t2_bubble_iwait", {31'b0, bus_if.iwait}, 32'd1);
        step();
        idle_inputs();
        step();
        step();

        // Simultaneous write and fetch: data first, then fetch after the bubble
        bus_if.iREN = 1'b1;
        bus_if.iaddr = 32'h44;
        bus_if.dWEN = 1'b1;
        bus_if.daddr = 32'h80;
        bus_if.dstore = 32'hDEAD_BEEF;
        step();
        mid();
        chk("t3_ramWEN", {31'b0, bus_if.ramWEN}, 32'd1);
        chk("t3_ramstore", bus_if.ramstore, 32'hDEAD_BEEF);
        chk("t3_ramaddr", bus_if.ramaddr, 32'h80);
        chk("t3_iwait_blocked", {31'b0, bus_if.iwait}, 32'd1);
        step();
        bus_if.ram_ready = 1'b1;
        mid();
        chk("t3_dwait_done", {31'b0, bus_if.dwait}, 32'd0);
        step();
        bus_if.ram_ready = 1'b0;
        bus_if.dWEN = 1'b0;
        mid();
        chk("t3_bubble_ramWEN", {31'b0, bus_if.ramWEN}, 32'd0);
        chk("t3_bubble_iwait", {31'b0, bus_if.iwait}, 32'd1);
        step();
        bus_if.ram_ready = 1'b1;
        mid();
        chk("t3_igrant_addr", bus_if.ramaddr, 32'h44);
        chk("t3_igrant_iwait", {31'b0, bus_if.iwait}, 32'd0);
        step();
        idle_inputs();
        step();
        step();

        // Contended twice in a row: fixed priority repeats data, round-robin switches to fetch
        bus_if.iREN = 1'b1;
        bus_if.iaddr = 32'h48;
        bus_if.dREN = 1'b1;
        bus_if.daddr = 32'h200;
        bus_if.ramload = 32'h0BAD_F00D;
        step();
        mid();
        chk("t3b_first_addr", bus_if.ramaddr, 32'h200);
        step();
        bus_if.ram_ready = 1'b1;
        mid();
        chk("t3b_dload", bus_if.dload, 32'h0BAD_F00D);
        step();
        bus_if.ram_ready = 1'b0;
        mid();
        chk("t3b_bubble_dwait", {31'b0, bus_if.dwait}, 32'd1);
        step();
        mid();
        chk("t3b_second_addr", bus_if.ramaddr, RR ? 32'h48 : 32'h200);
        step();
        idle_inputs();
        step();
        step();

        // Data read withdrawn before the RAM answers; pending fetch follows
        bus_if.iREN = 1'b1;
        bus_if.iaddr = 32'h4C;
        bus_if.dREN = 1'b1;
        bus_if.daddr = 32'h210;
        step();
        mid();
        chk("t4_ramREN_on", {31'b0, bus_if.ramREN}, 32'd1);
        chk("t4_ramaddr", bus_if.ramaddr, 32'h210);
        step();
        bus_if.dREN = 1'b0;
        mid();
        chk("t4_ramREN_dropped", {31'b0, bus_if.ramREN}, 32'd0);
        chk("t4_dwait_held", {31'b0, bus_if.dwait}, 32'd1);
        step();
        mid();
        chk("t4_idle_ramREN", {31'b0, bus_if.ramREN}, 32'd0);
        step();
        mid();
        chk("t4_igrant_addr", bus_if.ramaddr, 32'h4C);
        step();
        bus_if.ram_ready = 1'b1;
        mid();
        chk("t4_iwait_done", {31'b0, bus_if.iwait}, 32'd0);
        step();
        idle_inputs();
        step();
        step();

        // Fetch hangs: err after 8 unanswered grant cycles, then the fetch still completes
        bus_if.iREN = 1'b1;
        bus_if.iaddr = 32'h50;
        step();
        for (int k = 1; k <= TO; k++) begin
            mid();
            chk("t5_err_low", {31'b0, err}, 32'd0);
            step();
        end
        mid();
        chk("t5_err_set", {31'b0, err}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            mid();
            chk("t5_err_sat", {31'b0, err}, 32'd1);
        end
        step();
        bus_if.ram_ready = 1'b1;
        bus_if.ramload = 32'h7777_0001;
        mid();
        chk("t5_iwait_done", {31'b0, bus_if.iwait}, 32'd0);
        chk("t5_iload", bus_if.iload, 32'h7777_0001);
        chk("t5_err_kept", {31'b0, err}, 32'd1);
        step();
        idle_inputs();
        mid();
        chk("t5_err_sticky", {31'b0, err}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("t5_err_cleared", {31'b0, err}, 32'd0);
        step();
        nRST = 1'b1;
        step();

        // Back-to-back data reads; the second RAM answer arrives one grant cycle late
        bus_if.dREN = 1'b1;
        bus_if.daddr = 32'h100;
        mid();
        pat[4] = bus_if.dwait;
        step();
        bus_if.ram_ready = 1'b1;
        mid();
        pat[3] = bus_if.dwait;
        step();
        bus_if.ram_ready = 1'b0;
        bus_if.daddr = 32'h104;
        mid();
        pat[2] = bus_if.dwait;
        step();
        mid();
        pat[1] = bus_if.dwait;
        chk("t6_second_addr", bus_if.ramaddr, 32'h104);
        step();
        bus_if.ram_ready = 1'b1;
        mid();
        pat[0] = bus_if.dwait;
        chk("t6_dwait_pattern", {27'b0, pat}, 32'b10110);
        step();
        idle_inputs();
        step();
        step();

        // Random traffic with sticky requests so grants can run long enough to time out
        for (int c = 0; c < 2500; c++) begin
            nRST = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 4) == 0) bus_if.iREN = ~bus_if.iREN;
            if ($urandom_range(0, 4) == 0) bus_if.dREN = ~bus_if.dREN;
            if ($urandom_range(0, 6) == 0) bus_if.dWEN = ~bus_if.dWEN;
            if ($urandom_range(0, 3) == 0) bus_if.iaddr = $urandom;
            if ($urandom_range(0, 3) == 0) bus_if.daddr = $urandom;
            bus_if.dstore = $urandom;
            bus_if.ramload = $urandom;
            bus_if.ram_ready = ($urandom_range(0, 3) == 0);
            step();
        end
        nRST = 1'b1;
        idle_inputs();
        step();
        step();
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
